spi_master_ctrl: RTL and testbench

- Mode-0 SPI master that sits directly upstream of the `Slave` block and drives its `SCLK`, `CS` and `MOSI` inputs from the system clock.
- Sends one 8-bit word MSB-first on `MOSI` while capturing 8 bits from `MISO` into `masterDataReceived`.
- Host side uses a start/busy/done handshake; the SPI clock is derived from `clk` by a programmable divider.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_half_tick.sv | 25 ++
 rtl/spi_master_ctrl.sv | 122 ++++++++++++
 tb/tb_spi_master_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, default divider and word width.
package spi_pkg;

    localparam int SPI_DEFAULT_CLK_DIV = 4;
    localparam int SPI_WORD_W          = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        HOLD = 3'd4,
        GAP  = 3'd5
    } spi_state_e;

    // States during which chip select is held low and the master reports busy.
    function automatic logic in_frame(input spi_state_e st);
        return (st == LEAD) || (st == HIGH) || (st == LOW) || (st == HOLD);
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Reloadable half-period divider: tick pulses for one cycle every CLK_DIV cycles after a restart.
module spi_half_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    logic [7:0] cnt_r;

    assign tick = (cnt_r == 8'(CLK_DIV - 1));

    // Divider count 0..CLK_DIV-1, forced back to zero when the FSM changes state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (restart || tick) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master sending one word MSB-first per accepted start.
// Build option SPI_MASTER_LOOPBACK_EN feeds MOSI back into the receive path for self-test.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV,
    parameter int DATA_W  = SPI_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] masterDataToSend,
    output logic [DATA_W-1:0] masterDataReceived,
    output logic              busy,
    output logic              done,
    output logic              SCLK,
    output logic              CS,
    output logic              MOSI,
    input  logic              MISO
);
    localparam logic [3:0] BIT_LAST = 4'(DATA_W);

    spi_state_e        state_r;
    spi_state_e        state_s;
    logic              tick_s;
    logic              restart_s;
    logic              rx_bit_s;
    logic              accept_s;
    logic              high_entry_s;
    logic              shift_tx_s;
    logic              finish_s;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic [3:0]        bit_cnt_r;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso_s;
    assign unused_miso_s = MISO;
    assign rx_bit_s      = MOSI;
`else
    assign rx_bit_s = MISO;
`endif

    spi_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart_s),
        .tick   (tick_s)
    );

    // Next-state logic; the last HIGH goes straight to HOLD so SCLK falls for the 8th time there.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: if (start) state_s = LEAD; else state_s = IDLE;
            LEAD: if (tick_s) state_s = HIGH; else state_s = LEAD;
            HIGH: begin
                if (!tick_s)                     state_s = HIGH;
                else if (bit_cnt_r >= BIT_LAST)  state_s = HOLD;
                else                             state_s = LOW;
            end
            LOW: begin
                if (!tick_s)                     state_s = LOW;
                else if (bit_cnt_r < BIT_LAST)   state_s = HIGH;
                else                             state_s = HOLD;
            end
            HOLD: if (tick_s) state_s = GAP; else state_s = HOLD;
            GAP:  if (tick_s) state_s = IDLE; else state_s = GAP;
            default: state_s = IDLE;
        endcase
    end

    assign restart_s    = (state_s != state_r);
    assign accept_s     = (state_r == IDLE) && (state_s == LEAD);
    assign high_entry_s = (state_r != HIGH) && (state_s == HIGH);
    assign shift_tx_s   = (state_r == HIGH) && (state_s == LOW);
    assign finish_s     = (state_r == HOLD) && (state_s == GAP);

    // State, datapath and pin registers; pins are decoded from the next state so they change with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r            <= IDLE;
            tx_r               <= '0;
            rx_r               <= '0;
            bit_cnt_r          <= 4'd0;
            masterDataReceived <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            SCLK               <= 1'b0;
            CS                 <= 1'b1;
            MOSI               <= 1'b0;
        end else begin
            state_r <= state_s;
            SCLK    <= (state_s == HIGH);
            CS      <= ~in_frame(state_s);
            busy    <= in_frame(state_s);
            done    <= finish_s;
            if (accept_s) begin
                tx_r      <= masterDataToSend;
                MOSI      <= masterDataToSend[DATA_W-1];
                bit_cnt_r <= 4'd0;
            end else if (high_entry_s) begin
                rx_r <= {rx_r[DATA_W-2:0], rx_bit_s};
                if (bit_cnt_r != BIT_LAST) begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                end
            end else if (shift_tx_s) begin
                tx_r <= tx_r << 1;
                MOSI <= tx_r[DATA_W-2];
            end else if (finish_s) begin
                masterDataReceived <= rx_r;
            end else begin
                tx_r <= tx_r;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV 4 and 1), each with a behavioural SPI slave,
// checked every cycle against an edge-schedule model plus literal expectations.
module tb_spi_master_ctrl;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v   = 2'b00;
    logic [1:0] start_v = 2'b00;
    logic [7:0] tx_w [2];
    logic [7:0] slave_word [2];
    wire  [1:0] sclk_v, cs_v, mosi_v, busy_v, done_v, miso_v;
    wire  [7:0] rx0, rx1;
    logic [7:0] sl_out0 = 8'h00, sl_out1 = 8'h00, sl_in0 = 8'h00, sl_in1 = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_n [2] = '{-1000000, -1000000};
    logic [7:0] acc_word [2] = '{8'h00, 8'h00};
    logic [7:0] exp_word [2] = '{8'h00, 8'h00};
    logic [7:0] exp_rx   [2] = '{8'h00, 8'h00};
    bit has_sent [2] = '{1'b0, 1'b0};

    spi_master_ctrl #(.CLK_DIV(4), .DATA_W(8)) dut4 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .masterDataToSend(tx_w[0]),
        .masterDataReceived(rx0), .busy(busy_v[0]), .done(done_v[0]), .SCLK(sclk_v[0]),
        .CS(cs_v[0]), .MOSI(mosi_v[0]), .MISO(miso_v[0]));

    spi_master_ctrl #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .masterDataToSend(tx_w[1]),
        .masterDataReceived(rx1), .busy(busy_v[1]), .done(done_v[1]), .SCLK(sclk_v[1]),
        .CS(cs_v[1]), .MOSI(mosi_v[1]), .MISO(miso_v[1]));

    // Mode-0 slaves: present MSB while CS is high/falls, shift out on falling SCLK, sample on rising.
    assign miso_v[0] = sl_out0[7];
    assign miso_v[1] = sl_out1[7];
    always @(negedge sclk_v[0] or posedge cs_v[0] or slave_word[0]) begin
        if (cs_v[0]) sl_out0 = slave_word[0]; else sl_out0 = sl_out0 << 1;
    end
    always @(negedge sclk_v[1] or posedge cs_v[1] or slave_word[1]) begin
        if (cs_v[1]) sl_out1 = slave_word[1]; else sl_out1 = sl_out1 << 1;
    end
    always @(posedge sclk_v[0]) sl_in0 = {sl_in0[6:0], mosi_v[0]};
    always @(posedge sclk_v[1]) sl_in1 = {sl_in1[6:0], mosi_v[1]};

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic logic [7:0] get_rx(input int i);
        return (i == 0) ? rx0 : rx1;
    endfunction
    function automatic logic [7:0] get_slv(input int i);
        return (i == 0) ? sl_in0 : sl_in1;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d cycle %0d: got 0x%0h, required 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    // Model: a start is taken whenever the previous frame's 1+18*D cycle slot has elapsed.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_v[i]) begin
                acc_n[i]    = -1000000;
                has_sent[i] = 1'b0;
            end else if (start_v[i] && (cyc >= acc_n[i] + 1 + 18 * dv(i))) begin
                acc_n[i]    = cyc;
                acc_word[i] = tx_w[i];
                has_sent[i] = 1'b1;
                exp_word[i] = LOOPBACK ? tx_w[i] : slave_word[i];
            end
        end
        cyc = cyc + 1;
    end

    // Compare: pin levels follow the edge schedule measured from cycle N+1 of the last acceptance.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int t, d;
            bit fr, e_sclk, e_done, e_mosi;
            d = dv(i);
            t = cyc - (acc_n[i] + 1);
            if (!rst_v[i]) begin
                fr = 1'b0; e_sclk = 1'b0; e_done = 1'b0; e_mosi = 1'b0;
                exp_rx[i] = 8'h00;
            end else begin
                fr     = (t >= 0) && (t < 17 * d);
                e_sclk = (t >= d) && (t < 16 * d) && ((t / d) % 2 == 1);
                e_done = (t == 17 * d);
                if ((t >= 0) && (t < 16 * d)) e_mosi = acc_word[i][7 - t / (2 * d)];
                else                          e_mosi = has_sent[i] & acc_word[i][0];
                if (e_done) begin
                    exp_rx[i] = exp_word[i];
                    chk("slave_rx", i, get_slv(i), acc_word[i]);
                end
            end
            chk("cs", i, cs_v[i], !fr);
            chk("busy", i, busy_v[i], fr);
            chk("sclk", i, sclk_v[i], e_sclk);
            chk("done", i, done_v[i], e_done);
            chk("mosi", i, mosi_v[i], e_mosi);
            chk("rx_word", i, get_rx(i), exp_rx[i]);
        end
    end

    task automatic run(input int i, input logic [7:0] w, input logic [7:0] sw,
                       output int n, output int lat, output int hi);
        n = -1; lat = -1; hi = 0;
        tx_w[i] = w; slave_word[i] = sw; start_v[i] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy_v[i]) begin n = cyc - 1; break; end
        end
        start_v[i] = 1'b0;
        if (n < 0) begin chk("accept_timeout", i, 0, 1); return; end
        tx_w[i] = ~w;
        for (int k = 0; k < 3000; k++) begin
            if (sclk_v[i]) hi++;
            if (done_v[i]) begin lat = cyc - n; break; end
            @(negedge clk);
        end
        if (lat < 0) chk("done_timeout", i, 0, 1);
    endtask

    logic [7:0] pair_m [6] = '{8'b11110000, 8'hA5, 8'h00, 8'hFF, 8'h01, 8'h3C};
    logic [7:0] pair_s [6] = '{8'b11010110, 8'h5A, 8'hFF, 8'h00, 8'h80, 8'hC3};

    initial begin
        int n, lat, hi, prev_done, nd, edges;
        bit prev_sclk;
        tx_w = '{8'h00, 8'h00};
        slave_word = '{8'h00, 8'h00};
        repeat (3) @(negedge clk);
        rst_v = 2'b11;
        @(negedge clk);
        chk("reset_cs", 0, cs_v[0], 1);
        chk("reset_sclk", 0, sclk_v[0], 0);
        chk("reset_mosi", 0, mosi_v[0], 0);
        chk("reset_busy", 1, busy_v[1], 0);
        chk("reset_rx", 1, rx1, 8'h00);

        run(0, 8'b10110101, 8'b11001010, n, lat, hi);
        chk("lat_d4", 0, lat, 69);
        chk("rx_lit", 0, rx0, LOOPBACK ? 8'b10110101 : 8'b11001010);
        chk("slave_lit", 0, sl_in0, 8'b10110101);
        chk("sclk_hi_d4", 0, hi, 32);
        prev_done = n + lat;

        for (int k = 0; k < 6; k++) begin
            run(0, pair_m[k], pair_s[k], n, lat, hi);
            chk("cs_gap", 0, ((n + 1 - prev_done) >= 4), 1);
            chk("pair_rx", 0, rx0, LOOPBACK ? pair_m[k] : pair_s[k]);
            chk("pair_slave", 0, sl_in0, pair_m[k]);
            prev_done = n + lat;
        end

        repeat (10) @(negedge clk);
        tx_w[0] = 8'hAA; slave_word[0] = 8'h96; start_v[0] = 1'b1;
        nd = 0;
        repeat (200) begin @(negedge clk); if (done_v[0]) nd++; end
        start_v[0] = 1'b0;
        repeat (100) begin @(negedge clk); if (done_v[0]) nd++; end
        chk("held_dones", 0, nd, 3);
        chk("held_rx", 0, rx0, LOOPBACK ? 8'hAA : 8'h96);

        tx_w[0] = 8'h5C; slave_word[0] = 8'h3A; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        edges = 0; prev_sclk = 1'b0;
        for (int k = 0; k < 500 && edges < 3; k++) begin
            @(posedge clk); #1;
            if (sclk_v[0] && !prev_sclk) edges++;
            prev_sclk = sclk_v[0];
        end
        chk("third_edge_seen", 0, edges, 3);
        rst_v[0] = 1'b0;
        #1;
        chk("async_cs", 0, cs_v[0], 1);
        chk("async_sclk", 0, sclk_v[0], 0);
        chk("async_rx", 0, rx0, 8'h00);
        chk("async_done", 0, done_v[0], 0);
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        run(0, 8'h53, 8'hE1, n, lat, hi);
        chk("post_reset_lat", 0, lat, 69);
        chk("post_reset_rx", 0, rx0, LOOPBACK ? 8'h53 : 8'hE1);
        chk("post_reset_slave", 0, sl_in0, 8'h53);

        run(1, 8'b10000011, 8'h6E, n, lat, hi);
        chk("lat_d1", 1, lat, 18);
        chk("sclk_hi_d1", 1, hi, 8);
        chk("rx_d1", 1, rx1, LOOPBACK ? 8'b10000011 : 8'h6E);
        chk("slave_d1", 1, sl_in1, 8'b10000011);

        run(1, 8'b10011000, 8'h00, n, lat, hi);
        chk("miso_zero_rx", 1, rx1, LOOPBACK ? 8'b10011000 : 8'h00);

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
